// File: rtl/password_checker.sv
// Consumer end of the brute-force character stream. It holds a LEN-letter target, groups
// accepted candidate characters into LEN-character words, and flags the first exact match.
module password_checker #(
  parameter int unsigned LEN   = 4,
  parameter logic [7:0]  BASE  = 8'h61,
  parameter int unsigned ALPHA = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        tgt_valid,
  input  logic [7:0]  tgt_char,
  input  logic        cand_valid,
  input  logic [7:0]  cand_char,
  output logic        cand_ready,
  output logic [4:0]  cand_idx,
  output logic        found,
  output logic [15:0] found_count,
  output logic [15:0] checked_count,
  output logic        err
);

  localparam int unsigned PosW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [PosW-1:0] LastPos = PosW'(LEN - 1);

  typedef enum logic [1:0] {StEmpty, StLoading, StArmed, StFound} state_e;

  state_e                state_q, state_d;
  logic [LEN-1:0][7:0]   target_q, target_d;
  logic [PosW-1:0]       pos_q, pos_d;
  logic                  mismatch_q, mismatch_d;
  logic [15:0]           checked_q, checked_d;
  logic [15:0]           found_count_q, found_count_d;
  logic                  found_q, found_d;
  logic [4:0]            cand_idx_q, cand_idx_d;
  logic                  err_q, err_d;

  // Nine-bit subtraction so characters below BASE wrap negative instead of aliasing.
  function automatic logic is_legal(input logic [7:0] c);
    logic [8:0] d;
    d = {1'b0, c} - {1'b0, BASE};
    return !d[8] && (d < 9'(ALPHA));
  endfunction

  logic            tgt_legal;
  logic            cand_legal;
  logic            accept;
  logic            cand_mis;
  logic [PosW-1:0] tgt_base;
  logic [15:0]     checked_inc;

  assign tgt_legal   = is_legal(tgt_char);
  assign cand_legal  = is_legal(cand_char);
  assign cand_ready  = (state_q == StArmed);
  assign accept      = cand_valid && cand_ready;
  assign cand_mis    = !cand_legal || (cand_char != target_q[pos_q]);
  assign tgt_base    = (state_q == StLoading) ? pos_q : '0;
  assign checked_inc = (checked_q == 16'hFFFF) ? checked_q : checked_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    pos_d         = pos_q;
    mismatch_d    = mismatch_q;
    checked_d     = checked_q;
    found_count_d = found_count_q;
    found_d       = found_q;
    cand_idx_d    = cand_idx_q;
    err_d         = 1'b0;

    if (clear) begin
      checked_d     = '0;
      found_count_d = '0;
      found_d       = 1'b0;
      pos_d         = '0;
      mismatch_d    = 1'b0;
      if (state_q == StEmpty || state_q == StLoading) begin
        state_d  = StEmpty;
        target_d = '0;
      end else begin
        state_d = StArmed;
      end
    end else if (tgt_valid) begin
      // Any strobe outside LOADING starts a fresh target and a fresh search.
      checked_d     = '0;
      found_count_d = '0;
      found_d       = 1'b0;
      mismatch_d    = 1'b0;
      state_d       = StLoading;
      pos_d         = tgt_base;
      if (tgt_legal) begin
        target_d[tgt_base] = tgt_char;
        if (tgt_base == LastPos) begin
          state_d = StArmed;
          pos_d   = '0;
        end else begin
          pos_d = tgt_base + PosW'(1);
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (accept) begin
      cand_idx_d = cand_legal ? 5'(cand_char - BASE) : 5'd31;
      err_d      = !cand_legal;
      if (pos_q == LastPos) begin
        checked_d  = checked_inc;
        pos_d      = '0;
        mismatch_d = 1'b0;
        if (!(mismatch_q || cand_mis)) begin
          found_d       = 1'b1;
          found_count_d = checked_inc;
          state_d       = StFound;
        end
      end else begin
        pos_d      = pos_q + PosW'(1);
        mismatch_d = mismatch_q | cand_mis;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StEmpty;
      target_q      <= '0;
      pos_q         <= '0;
      mismatch_q    <= 1'b0;
      checked_q     <= '0;
      found_count_q <= '0;
      found_q       <= 1'b0;
      cand_idx_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      pos_q         <= pos_d;
      mismatch_q    <= mismatch_d;
      checked_q     <= checked_d;
      found_count_q <= found_count_d;
      found_q       <= found_d;
      cand_idx_q    <= cand_idx_d;
      err_q         <= err_d;
    end
  end

  assign cand_idx      = cand_idx_q;
  assign found         = found_q;
  assign found_count   = found_count_q;
  assign checked_count = checked_q;
  assign err           = err_q;

endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker: target loads, matching and non-matching candidates,
// illegal characters, clear and mid-candidate reset, against hand-computed values.
module tb_password_checker;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        tgt_valid;
  logic [7:0]  tgt_char;
  logic        cand_valid;
  logic [7:0]  cand_char;
  logic        cand_ready;
  logic [4:0]  cand_idx;
  logic        found;
  logic [15:0] found_count;
  logic [15:0] checked_count;
  logic        err;

  int checks   = 0;
  int failures = 0;

  password_checker #(
    .LEN  (4),
    .BASE (8'h61),
    .ALPHA(26)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .tgt_valid    (tgt_valid),
    .tgt_char     (tgt_char),
    .cand_valid   (cand_valid),
    .cand_char    (cand_char),
    .cand_ready   (cand_ready),
    .cand_idx     (cand_idx),
    .found        (found),
    .found_count  (found_count),
    .checked_count(checked_count),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic er, input logic [4:0] ei,
                         input logic ef, input logic [15:0] efc, input logic [15:0] ecc,
                         input logic ee);
    checks++;
    assert (cand_ready === er) else begin
      failures++;
      $error("FAIL %s.cand_ready observed=%0b expected=%0b", tag, cand_ready, er);
    end
    checks++;
    assert (cand_idx === ei) else begin
      failures++;
      $error("FAIL %s.cand_idx observed=%0d expected=%0d", tag, cand_idx, ei);
    end
    checks++;
    assert (found === ef) else begin
      failures++;
      $error("FAIL %s.found observed=%0b expected=%0b", tag, found, ef);
    end
    checks++;
    assert (found_count === efc) else begin
      failures++;
      $error("FAIL %s.found_count observed=%0d expected=%0d", tag, found_count, efc);
    end
    checks++;
    assert (checked_count === ecc) else begin
      failures++;
      $error("FAIL %s.checked_count observed=%0d expected=%0d", tag, checked_count, ecc);
    end
    checks++;
    assert (err === ee) else begin
      failures++;
      $error("FAIL %s.err observed=%0b expected=%0b", tag, err, ee);
    end
  endtask

  task automatic load(input logic [7:0] c);
    tgt_valid = 1'b1;
    tgt_char  = c;
    tick();
    tgt_valid = 1'b0;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) load(s[i]);
  endtask

  task automatic cand(input logic [7:0] c);
    cand_valid = 1'b1;
    cand_char  = c;
    tick();
    cand_valid = 1'b0;
  endtask

  task automatic cand_str(input string s);
    for (int i = 0; i < s.len(); i++) cand(s[i]);
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_char   = 8'h00;
    cand_valid = 1'b0;
    cand_char  = 8'h00;
    repeat (2) tick();
    chk_out("reset", 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle_empty", 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);

    // Target "abcz", candidates "abca" then "abcz".
    load_str("abc");
    chk_out("load3", 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    load("z");
    chk_out("armed1", 1'b1, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    cand("a");
    chk_out("c1_a", 1'b1, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    cand("b");
    chk_out("c1_b", 1'b1, 5'd1, 1'b0, 16'd0, 16'd0, 1'b0);
    cand_str("ca");
    chk_out("c1_done", 1'b1, 5'd0, 1'b0, 16'd0, 16'd1, 1'b0);
    cand_str("abc");
    chk_out("c2_abc", 1'b1, 5'd2, 1'b0, 16'd0, 16'd1, 1'b0);
    cand("z");
    chk_out("c2_found", 1'b0, 5'd25, 1'b1, 16'd2, 16'd2, 1'b0);
    cand("#");
    chk_out("ignored_in_found", 1'b0, 5'd25, 1'b1, 16'd2, 16'd2, 1'b0);

    // Target "zzzz", 100 non-matching "aaaa" candidates.
    load("z");
    chk_out("reload_clears", 1'b0, 5'd25, 1'b0, 16'd0, 16'd0, 1'b0);
    load_str("zzz");
    chk_out("armed2", 1'b1, 5'd25, 1'b0, 16'd0, 16'd0, 1'b0);
    for (int n = 0; n < 100; n++) begin
      for (int k = 0; k < 4; k++) begin
        cand("a");
        chk_out("stream", 1'b1, 5'd0, 1'b0, 16'd0, 16'(n + ((k == 3) ? 1 : 0)), 1'b0);
      end
    end

    // Illegal 'A' mid-candidate.
    load_str("abcd");
    chk_out("armed3", 1'b1, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    cand("a");
    chk_out("ill_a", 1'b1, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    cand(8'h41);
    chk_out("ill_A", 1'b1, 5'd31, 1'b0, 16'd0, 16'd0, 1'b1);
    cand("c");
    chk_out("ill_c", 1'b1, 5'd2, 1'b0, 16'd0, 16'd0, 1'b0);
    cand("d");
    chk_out("ill_done", 1'b1, 5'd3, 1'b0, 16'd0, 16'd1, 1'b0);

    // Target load with an illegal '#' in the middle.
    load_str("ab");
    chk_out("tl_ab", 1'b0, 5'd3, 1'b0, 16'd0, 16'd0, 1'b0);
    load("#");
    chk_out("tl_hash", 1'b0, 5'd3, 1'b0, 16'd0, 16'd0, 1'b1);
    load("c");
    chk_out("tl_c", 1'b0, 5'd3, 1'b0, 16'd0, 16'd0, 1'b0);
    load("d");
    chk_out("tl_armed", 1'b1, 5'd3, 1'b0, 16'd0, 16'd0, 1'b0);
    cand_str("abcd");
    chk_out("tl_found", 1'b0, 5'd3, 1'b1, 16'd1, 16'd1, 1'b0);

    // Clear after found keeps the target.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_out("clr_armed", 1'b1, 5'd3, 1'b0, 16'd0, 16'd0, 1'b0);
    cand_str("abcd");
    chk_out("clr_found", 1'b0, 5'd3, 1'b1, 16'd1, 16'd1, 1'b0);

    // Reset mid-candidate after "ab".
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cand("a");
    cand("b");
    chk_out("pre_rst", 1'b1, 5'd1, 1'b0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    cand("c");
    chk_out("rst_no_accept", 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);

    // Clear during loading discards the partial target.
    load_str("xy");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_out("clr_loading", 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    load_str("abc");
    chk_out("reload3", 1'b0, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    load("d");
    chk_out("reload_armed", 1'b1, 5'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    cand_str("abcd");
    chk_out("reload_found", 1'b0, 5'd3, 1'b1, 16'd1, 16'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
